// File: rtl/seq_shift_pkg.sv
// rtl/seq_shift_pkg.sv - op codes and FSM state encoding for the iterative shifter
package seq_shift_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SAR  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit shift/rotate step, combinational
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Select the single-position move for the latched operation; pass and reserved codes hold
    always_comb begin
        q = d;
        case (op)
            OP_SHR:  q = {1'b0, d[WIDTH-1:1]};
            OP_SHL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SAR:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROR:  q = {d[0], d[WIDTH-1:1]};
            OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/seq_shift_rotate.sv
// rtl/seq_shift_rotate.sv - handshaked iterative shift/rotate unit, one bit per clock
module seq_shift_rotate
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    eff;
    logic [WIDTH-1:0] step_d;

    // Effective step count: shifts saturate at WIDTH, rotates wrap modulo WIDTH, pass does nothing
    always_comb begin
        eff = '0;
        case (op)
            OP_SHR, OP_SHL, OP_SAR: eff = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;
            OP_ROR, OP_ROL:         eff = {1'b0, amt[AW-2:0]};
            default:                eff = '0;
        endcase
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op(op_q),
        .d (dout),
        .q (step_d)
    );

    // Control FSM, step counter and working register; reset overrides any pending request
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= OP_PASS;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dout  <= din;
                        op_q  <= op;
                        cnt   <= eff;
                        state <= (eff != '0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    dout <= step_d;
                    cnt  <= cnt - 1'b1;
                    if (cnt == AW'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
